serial_compare_scheduler: RTL and testbench

- Shares one MSB-first bit-serial magnitude comparator core between N_REQ requesters.
- Each requester presents parallel W-bit operands a/b with a valid/ready handshake.
- The scheduler arbitrates round-robin, shifts the winner's operands MSB-first through the core, and returns less/eq/greater tagged with the requester id on a valid/ready result port.
- Sits between parallel-operand clients and the serial comparator datapath.

---
 rtl/serial_cmp_pkg.sv | 16 +
 rtl/serial_compare_scheduler_core.sv | 46 ++++
 rtl/serial_compare_scheduler.sv | 171 +++++++++++++++++
 tb/tb_serial_compare_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the round-robin scheduler around the bit-serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_LESS,
        CMP_GREATER
    } cmp_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/serial_compare_scheduler_core.sv
// MSB-first bit-serial magnitude comparator: sticky EQ/LESS/GREATER state,
// decided by the first differing bit pair and held until cleared.
module serial_cmp_msb_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic less,
    output logic eq,
    output logic greater
);

    cmp_state_t state_q;
    cmp_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CMP_EQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Once a difference is seen, lower-order bits can no longer change the verdict.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = CMP_EQ;
        end else if (en && state_q == CMP_EQ) begin
            if (a && !b) begin
                state_d = CMP_GREATER;
            end else if (!a && b) begin
                state_d = CMP_LESS;
            end
        end
    end

    assign less    = (state_q == CMP_LESS);
    assign eq      = (state_q == CMP_EQ);
    assign greater = (state_q == CMP_GREATER);

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one bit-serial comparator core among N_REQ requesters.
// Build option: SERIAL_CMP_EARLY_EXIT_EN ends a comparison at the first differing bit.
module serial_compare_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int W     = 8,
    parameter int N_REQ = 2
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_less,
    output logic                       res_eq,
    output logic                       res_greater,
    output logic [$clog2(W+1)-1:0]     res_bits
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int BITS_W = $clog2(W+1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   grant_idx;
    logic [W-1:0]      a_sh_q;
    logic [W-1:0]      b_sh_q;
    logic [W-1:0]      grant_a;
    logic [W-1:0]      grant_b;
    logic [BITS_W-1:0] cnt_q;
    logic [BITS_W-1:0] bits_q;
    logic              any_valid;
    logic              xfer;
    logic              core_less;
    logic              core_eq;
    logic              core_greater;

    // First valid requester at or after ptr, wrapping to the lowest index otherwise.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && v[i] && ID_W'(i) >= ptr) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && v[i]) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_valid = |req_valid;
    assign grant_idx = rr_pick(req_valid, rr_ptr_q);
    assign rr_next   = (int'(id_q) == N_REQ - 1) ? '0 : id_q + ID_W'(1);

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                grant_a = req_a[i*W +: W];
                grant_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        xfer      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready = N_REQ'(1) << grant_idx;
                    xfer      = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (cnt_q == BITS_W'(1) || a_sh_q[W-1] != b_sh_q[W-1]) begin
                    state_d = S_DONE;
                end
`else
                if (cnt_q == BITS_W'(1)) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            cnt_q    <= '0;
            bits_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (xfer) begin
                a_sh_q <= grant_a;
                b_sh_q <= grant_b;
                id_q   <= grant_idx;
                cnt_q  <= BITS_W'(W);
                bits_q <= '0;
            end else if (state_q == S_SHIFT) begin
                a_sh_q <= {a_sh_q[W-2:0], 1'b0};
                b_sh_q <= {b_sh_q[W-2:0], 1'b0};
                cnt_q  <= cnt_q - BITS_W'(1);
                bits_q <= bits_q + BITS_W'(1);
            end
            if (state_q == S_DONE && res_ready) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

    serial_cmp_msb_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (xfer),
        .en      (state_q == S_SHIFT),
        .a       (a_sh_q[W-1]),
        .b       (b_sh_q[W-1]),
        .less    (core_less),
        .eq      (core_eq),
        .greater (core_greater)
    );

    // Result flags are only meaningful in DONE; masking keeps them 0 out of reset.
    assign res_valid   = (state_q == S_DONE);
    assign res_less    = res_valid & core_less;
    assign res_eq      = res_valid & core_eq;
    assign res_greater = res_valid & core_greater;
    assign res_id      = id_q;
    assign res_bits    = bits_q;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed bench for serial_compare_scheduler (W=8, N_REQ=2), either build of SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_compare_scheduler;

    localparam int W      = 8;
    localparam int N_REQ  = 2;
    localparam int ID_W   = 1;
    localparam int BITS_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*W-1:0]   req_a;
    logic [N_REQ*W-1:0]   req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic                 res_less;
    logic                 res_eq;
    logic                 res_greater;
    logic [BITS_W-1:0]    res_bits;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
        logic       l;
        logic       e;
        logic       g;
        int         bits_full;
        int         bits_early;
    } vec_t;

    vec_t vecs[7];

    serial_compare_scheduler #(.W(W), .N_REQ(N_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_less    (res_less),
        .res_eq      (res_eq),
        .res_greater (res_greater),
        .res_bits    (res_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_bits(input int full, input int early);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return early;
`else
        return full;
`endif
    endfunction

    task automatic wait_ready(input int r);
        int n;
        n = 0;
        #1;
        while (!req_ready[r] && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        @(negedge clk); #1;
        while (!res_valid && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic run_txn(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic l, input logic e, input logic g,
                           input int bits, input string tag);
        int t0;
        int n;
        @(negedge clk);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_valid[r]    = 1'b1;
        wait_ready(r);
        check($sformatf("%s.grant", tag), 32'(req_ready), 32'(1) << r);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        wait_result(n);
        check($sformatf("%s.valid", tag), 32'(res_valid), 32'(1));
        check($sformatf("%s.latency", tag), 32'(cyc - t0), 32'(bits + 1));
        check($sformatf("%s.less", tag), 32'(res_less), 32'(l));
        check($sformatf("%s.eq", tag), 32'(res_eq), 32'(e));
        check($sformatf("%s.greater", tag), 32'(res_greater), 32'(g));
        check($sformatf("%s.id", tag), 32'(res_id), 32'(r));
        check($sformatf("%s.bits", tag), 32'(res_bits), 32'(bits));
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.req_ready", tag), 32'(req_ready), 32'(0));
        check($sformatf("%s.res_valid", tag), 32'(res_valid), 32'(0));
        check($sformatf("%s.res_id", tag), 32'(res_id), 32'(0));
        check($sformatf("%s.res_flags", tag), 32'({res_less, res_eq, res_greater}), 32'(0));
        check($sformatf("%s.res_bits", tag), 32'(res_bits), 32'(0));
    endtask

    initial begin
        logic [31:0] snap;
        int          n;
        int          t0;
        logic        ok;

        vecs[0] = '{0, 8'h41, 8'h46, 1'b1, 1'b0, 1'b0, 8, 6};
        vecs[1] = '{1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8, 8};
        vecs[2] = '{0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 8, 1};
        vecs[3] = '{1, 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b0, 8, 8};
        vecs[4] = '{1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8, 1};
        vecs[5] = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8, 8};
        vecs[6] = '{1, 8'h10, 8'h08, 1'b0, 1'b0, 1'b1, 8, 4};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held valid: grants must alternate starting from 0.
        @(negedge clk);
        req_a     = {8'h56, 8'h12};
        req_b     = {8'h56, 8'h34};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 30) begin
                @(negedge clk); #1;
                n++;
            end
            check($sformatf("rr%0d.grant", k), 32'(req_ready), 32'(1) << (k % 2));
            ok = 1'b1;
            n  = 0;
            @(negedge clk); #1;
            while (!res_valid && n < 40) begin
                if (req_ready != '0) ok = 1'b0;
                @(negedge clk); #1;
                n++;
            end
            check($sformatf("rr%0d.no_accept", k), 32'(ok), 32'(1));
            check($sformatf("rr%0d.id", k), 32'(res_id), 32'(k % 2));
            check($sformatf("rr%0d.flags", k), 32'({res_less, res_eq, res_greater}),
                  (k % 2 == 0) ? 32'(3'b100) : 32'(3'b010));
            if (k == 3) req_valid = '0;
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].e, vecs[i].g,
                    exp_bits(vecs[i].bits_full, vecs[i].bits_early), $sformatf("vec%0d", i));
        end

        // Consumer stall in DONE with another requester waiting.
        @(negedge clk);
        res_ready = 1'b0;
        req_a[W +: W] = 8'hC3;
        req_b[W +: W] = 8'hC4;
        req_valid[1]  = 1'b1;
        wait_ready(1);
        check("stall.grant", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1;
        req_valid[1]  = 1'b0;
        req_a[0 +: W] = 8'h20;
        req_b[0 +: W] = 8'h10;
        req_valid[0]  = 1'b1;
        wait_result(n);
        check("stall.valid", 32'(res_valid), 32'(1));
        check("stall.id", 32'(res_id), 32'(1));
        check("stall.less", 32'(res_less), 32'(1));
        check("stall.bits", 32'(res_bits), 32'(exp_bits(8, 6)));
        snap = 32'({res_valid, res_id, res_less, res_eq, res_greater, res_bits});
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (32'({res_valid, res_id, res_less, res_eq, res_greater, res_bits}) !== snap) ok = 1'b0;
            if (req_ready != '0) ok = 1'b0;
        end
        check("stall.stable", 32'(ok), 32'(1));
        res_ready = 1'b1;
        @(negedge clk); #1;
        check("stall.released", 32'(res_valid), 32'(0));
        check("stall.next_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_result(n);
        check("stall.after.id", 32'(res_id), 32'(0));
        check("stall.after.greater", 32'(res_greater), 32'(1));

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        req_a[0 +: W] = 8'h5A;
        req_b[0 +: W] = 8'h5B;
        req_valid[0]  = 1'b1;
        wait_ready(0);
        check("rst.grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk); #1;
            if (res_valid !== 1'b0) ok = 1'b0;
        end
        check("rst.no_result", 32'(ok), 32'(1));
        run_txn(0, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, exp_bits(8, 7), "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
